// File: rtl/seg_serial_driver_pkg.sv
// Shared constants, FSM state type and segment lookup for the serial 7-segment driver.
package seg_serial_driver_pkg;

  localparam int unsigned SEG_BYTE_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_LATCH
  } state_e;

  // Active-high segments {a,b,c,d,e,f,g} for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h7E;
      4'h1: seg = 7'h30;
      4'h2: seg = 7'h6D;
      4'h3: seg = 7'h79;
      4'h4: seg = 7'h33;
      4'h5: seg = 7'h5B;
      4'h6: seg = 7'h5F;
      4'h7: seg = 7'h70;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h7B;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h1F;
      4'hC: seg = 7'h4E;
      4'hD: seg = 7'h3D;
      4'hE: seg = 7'h4F;
      default: seg = 7'h47;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg_serial_driver_encoder.sv
// Combinational hex nibble + dp + blank to segment byte {a..g,dp}.
module seg_hex_encoder
  import seg_serial_driver_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0]            nibble_i,
  input  logic                  dp_i,
  input  logic                  blank_i,
  output logic [SEG_BYTE_W-1:0] seg_o
);

  logic [SEG_BYTE_W-1:0] seg_hi;

  // Build the active-high byte, then apply the board's drive polarity.
  always_comb begin
    seg_hi = blank_i ? '0 : {hex_to_seg(nibble_i), dp_i};
    seg_o  = ACTIVE_LOW ? ~seg_hi : seg_hi;
  end

endmodule

// File: rtl/seg_serial_driver.sv
// Serialises N encoded seven-segment digits into an external shift-register chain,
// with its own refresh timer, one-deep pending request and busy/done status.
module seg_serial_driver
  import seg_serial_driver_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 8,
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned REFRESH_CYCLES = 65536,
  parameter bit          ACTIVE_LOW     = 1'b1,
  parameter bit          DIR            = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] num,
  input  logic [NUM_DIGITS-1:0]   dot,
  input  logic [NUM_DIGITS-1:0]   blank,
  input  logic                    load_req,
  output logic                    s_clk,
  output logic                    s_clrn,
  output logic                    sout,
  output logic                    EN,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned FRAME_W = SEG_BYTE_W * NUM_DIGITS;
  localparam int unsigned BIT_W   = $clog2(FRAME_W);
  localparam int unsigned DIV_W   = $clog2(CLK_DIV) + 1;
  localparam int unsigned REF_W   = $clog2(REFRESH_CYCLES);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_CYCLES - 1);

  state_e               state_q, state_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [REF_W-1:0]     ref_q, ref_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic                 pending_q, pending_d;
  logic                 s_clk_q, s_clk_d;
  logic                 sout_q, sout_d;
  logic                 en_q, en_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 s_clrn_q;

  logic                 tick;
  logic                 req;
  logic                 div_last;
  logic [FRAME_W-1:0]   seg_all;
  logic [FRAME_W-1:0]   frame_load;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
    seg_hex_encoder #(
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_enc (
      .nibble_i(num[4*d +: 4]),
      .dp_i    (dot[d]),
      .blank_i (blank[d]),
      .seg_o   (seg_all[SEG_BYTE_W*d +: SEG_BYTE_W])
    );
  end

  // Frame is always shifted out MSB first; DIR=1 is handled by bit-reversing on load.
  always_comb begin
    frame_load = seg_all;
    if (DIR) begin
      for (int unsigned i = 0; i < FRAME_W; i++) begin
        frame_load[i] = seg_all[FRAME_W-1-i];
      end
    end
  end

  // Free-running refresh timer; tick on its last count.
  always_comb begin
    tick  = (ref_q == REF_LAST);
    ref_d = tick ? '0 : ref_q + REF_W'(1);
    req   = tick | load_req;
  end

  // FSM next state, counters, pending flag and next output values.
  // Outputs are registered from the next state so every pin comes straight off a flop.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    frame_d   = frame_q;
    div_last  = (div_q == DIV_LAST);
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        div_d = '0;
        if (pending_q || req) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        frame_d = frame_load;
        bit_d   = '0;
        div_d   = '0;
        state_d = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        if (div_last) begin
          div_d   = '0;
          state_d = ST_SHIFT_HI;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_SHIFT_HI: begin
        if (div_last) begin
          div_d   = '0;
          frame_d = {frame_q[FRAME_W-2:0], 1'b0};
          if (bit_q == BIT_LAST) begin
            bit_d   = '0;
            state_d = ST_LATCH;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            state_d = ST_SHIFT_LO;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_LATCH: begin
        if (div_last) begin
          div_d   = '0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Entering LOAD consumes the request; any other request collapses into one follow-up.
    if (state_q == ST_IDLE && state_d == ST_LOAD) pending_d = 1'b0;
    else if (req)                                 pending_d = 1'b1;
    else                                          pending_d = pending_q;

    s_clk_d = (state_d == ST_SHIFT_HI);
    en_d    = (state_d == ST_LATCH);
    busy_d  = (state_d != ST_IDLE);
    sout_d  = ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) ? frame_d[FRAME_W-1] : 1'b0;
  end

  // State, counters and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      ref_q     <= '0;
      frame_q   <= '0;
      pending_q <= 1'b0;
      s_clk_q   <= 1'b0;
      sout_q    <= 1'b0;
      en_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s_clrn_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      ref_q     <= ref_d;
      frame_q   <= frame_d;
      pending_q <= pending_d;
      s_clk_q   <= s_clk_d;
      sout_q    <= sout_d;
      en_q      <= en_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      s_clrn_q  <= 1'b1;
    end
  end

  assign s_clk  = s_clk_q;
  assign s_clrn = s_clrn_q;
  assign sout   = sout_q;
  assign EN     = en_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_seg_serial_driver.sv
// Scoreboard bench: a frame-level reference model predicts when each frame starts and
// what bits it carries; a monitor reassembles frames from the serial pins and compares.
module tb_seg_serial_driver;

  localparam int ND        = 8;
  localparam int CD        = 2;
  localparam int RC        = 512;
  localparam int NBITS     = 8 * ND;
  localparam int FRAME_LEN = 1 + 2 * CD * NBITS + CD;

  // Common-anode bytes for hex digits 0..F (segment on = 0, dp off).
  localparam logic [7:0] LUT_AL [16] = '{
    8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
    8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
  };

  typedef struct {
    logic [63:0] bits;
    int          start;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] num;
  logic [7:0]  dot;
  logic [7:0]  blank;
  logic        load_req;
  logic        s_clk, s_clrn, sout, EN, busy, done;

  int checks = 0;
  int errors = 0;

  exp_t exp_q[$];
  int   cyc         = 0;
  int   m_rc        = 0;
  bit   m_pend      = 1'b0;
  int   m_idle_from = 0;
  int   m_load      = -1000;
  bit   m_rst_edge  = 1'b1;

  bit          in_frame  = 1'b0;
  bit          prev_busy = 1'b0;
  bit          prev_sclk = 1'b0;
  bit          prev_done = 1'b0;
  int          start_cyc = 0;
  int          busy_len  = 0;
  int          en_len    = 0;
  int          cap_n     = 0;
  int          n_done    = 0;
  logic [63:0] bits      = '0;

  seg_serial_driver #(
    .NUM_DIGITS    (ND),
    .CLK_DIV       (CD),
    .REFRESH_CYCLES(RC),
    .ACTIVE_LOW    (1'b1),
    .DIR           (1'b0)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .num     (num),
    .dot     (dot),
    .blank   (blank),
    .load_req(load_req),
    .s_clk   (s_clk),
    .s_clrn  (s_clrn),
    .sout    (sout),
    .EN      (EN),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Frame as sent with DIR=0: digit ND-1 first, each byte MSB first.
  function automatic logic [63:0] model_frame(input logic [31:0] n, input logic [7:0] dt,
                                              input logic [7:0] bl);
    logic [63:0] f;
    logic [7:0]  b;
    f = '0;
    for (int d = ND - 1; d >= 0; d--) begin
      b = bl[d] ? 8'hFF : (LUT_AL[n[4*d +: 4]] & (dt[d] ? 8'hFE : 8'hFF));
      f = {f[55:0], b};
    end
    return f;
  endfunction

  // Reference model: requests (load_req or timer wrap) start a frame when idle,
  // otherwise collapse into one pending follow-up; contents snapshot in the LOAD cycle.
  always @(posedge clk) begin
    bit tick, req, idle;
    exp_t e;
    cyc = cyc + 1;
    if (rst) begin
      m_rc        = 0;
      m_pend      = 1'b0;
      m_idle_from = cyc;
      m_load      = -1000;
      exp_q.delete();
      m_rst_edge  = 1'b1;
    end else begin
      m_rst_edge = 1'b0;
      tick = (m_rc == RC - 1);
      req  = load_req || tick;
      if (cyc - 1 == m_load) begin
        e.bits  = model_frame(num, dot, blank);
        e.start = m_load;
        exp_q.push_back(e);
      end
      idle = (cyc - 1 >= m_idle_from);
      if (idle && (m_pend || req)) begin
        m_load      = cyc;
        m_idle_from = cyc + FRAME_LEN;
        m_pend      = 1'b0;
      end else if (req) begin
        m_pend = 1'b1;
      end
      m_rc = (m_rc == RC - 1) ? 0 : m_rc + 1;
    end
  end

  // Monitor: rebuilds frames from s_clk rising edges and checks them against the queue on done.
  always @(negedge clk) begin
    exp_t e;
    if (m_rst_edge) begin
      chk("reset_outputs", 64'({s_clrn, s_clk, sout, EN, busy, done}), 64'd0);
      in_frame  = 1'b0;
      prev_busy = 1'b0;
      prev_sclk = 1'b0;
      prev_done = 1'b0;
      cap_n     = 0;
    end else begin
      chk("s_clrn_high", 64'(s_clrn), 64'd1);
      if (busy && !prev_busy) begin
        in_frame  = 1'b1;
        start_cyc = cyc;
        busy_len  = 0;
        en_len    = 0;
        cap_n     = 0;
        bits      = '0;
      end
      if (busy) busy_len++;
      if (s_clk && !prev_sclk) begin
        bits = {bits[62:0], sout};
        cap_n++;
      end
      if (EN) en_len++;
      if (!in_frame) chk("idle_en_sclk", 64'({EN, s_clk}), 64'd0);
      if (done) begin
        n_done++;
        chk("done_single", 64'(prev_done), 64'd0);
        chk("frame_started", 64'(in_frame), 64'd1);
        chk("frame_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("frame_bits", bits, e.bits);
          chk("frame_start", 64'(start_cyc), 64'(e.start));
        end
        chk("bit_count", 64'(cap_n), 64'(NBITS));
        chk("busy_len", 64'(busy_len), 64'(FRAME_LEN));
        chk("en_len", 64'(en_len), 64'(CD));
        chk("busy_after_done", 64'(busy), 64'd0);
        in_frame = 1'b0;
      end
      prev_busy = busy;
      prev_sclk = s_clk;
      prev_done = done;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    step();
    load_req = 1'b0;
  endtask

  task automatic wait_done(input int maxc);
    int n0;
    int k;
    n0 = n_done;
    k  = 0;
    while (n_done == n0 && k < maxc) begin
      step();
      k++;
    end
    chk("done_seen", 64'(n_done > n0), 64'd1);
  endtask

  task automatic wait_busy(input int maxc);
    int k;
    k = 0;
    while (!busy && k < maxc) begin
      step();
      k++;
    end
    chk("busy_seen", 64'(busy), 64'd1);
  endtask

  initial begin
    int k;
    rst      = 1'b1;
    load_req = 1'b0;
    num      = '0;
    dot      = '0;
    blank    = '0;
    repeat (3) step();
    rst = 1'b0;
    repeat (20) step();

    // Basic frame: seven 0s then a 1.
    num = 32'h0000_0001;
    pulse_load();
    wait_done(700);

    // Blank on top digit, dp on digit 0.
    dot   = 8'h01;
    blank = 8'h80;
    num   = 32'hF000_000A;
    pulse_load();
    wait_done(700);

    // Input change after LOAD must not disturb the frame in flight.
    dot   = 8'h00;
    blank = 8'h00;
    num   = 32'h1234_5678;
    pulse_load();
    wait_busy(700);
    repeat (5) step();
    num = 32'h9ABC_DEF0;
    wait_done(700);
    pulse_load();
    wait_done(700);

    // Two load_reqs plus a timer tick during one frame -> one follow-up frame.
    k = 0;
    while (m_rc != RC - 150 && k < 1000) begin
      step();
      k++;
    end
    wait_done(700);
    num = 32'h0F1E_2D3C;
    pulse_load();
    repeat (30) step();
    num = 32'h4B5A_6978;
    pulse_load();
    repeat (40) step();
    pulse_load();
    wait_done(700);
    wait_done(700);

    // Reset in the middle of a frame, then a clean frame.
    num = 32'h8765_4321;
    pulse_load();
    k = 0;
    while (cap_n < 20 && k < 1000) begin
      step();
      k++;
    end
    chk("bit20_reached", 64'(cap_n >= 20), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (5) step();
    pulse_load();
    wait_done(700);

    // Random contents and request timing.
    for (int it = 0; it < 12; it++) begin
      num   = $urandom;
      dot   = 8'($urandom);
      blank = 8'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 1) == 1) pulse_load();
      repeat ($urandom_range(1, 350)) step();
      if ($urandom_range(0, 3) == 0) num = $urandom;
    end

    // Idle: only the refresh timer starts frames.
    repeat (1300) step();

    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (busy && k < 700);
    chk("drain_idle", 64'(busy), 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("frames_seen", 64'(n_done >= 10), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
